seq_frame_rx: RTL
=================

Name: seq_frame_rx

Overview:
- Parametrised serial frame receiver: hunts a configurable header pattern on a 1-bit stream, then deserialises NUM_BYTES payload words plus one checksum word, MSB first.
- Verifies the checksum in sum or XOR mode and presents the payload on a flat parallel bus with a one-cycle frame strobe and a saturating error counter.
- Sits behind the serial input pin logic and feeds display/decode logic; next generation of the fixed 4-byte, sum-only sequence reader.

Parameters:
- DATA_W, 8, bits per payload/checksum word (4..16)
- NUM_BYTES, 4, payload words per frame (1..16)
- HEAD_W, 8, header length in bits (2..16)
- HEAD_PAT, 8'hA5, header pattern; first-received bit is MSB
- CHK_MODE, 0, 0 = sum modulo 2^DATA_W, 1 = bitwise XOR of payload words
- ERR_W, 8, width of error counter

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- bit_en  in  1  qualifies data_in; a bit is consumed only on edges where bit_en=1
- data_in  in  1  serial data
- out_data  out  NUM_BYTES*DATA_W  payload; word 0 (first received) in the top DATA_W bits
- out_chk  out  DATA_W  received checksum word
- frame_valid  out  1  one-cycle strobe: new frame on out_data/out_chk
- check_ok  out  1  checksum matched for latest frame; held until next frame
- busy  out  1  high while not in HUNT
- head  out  1  one-cycle pulse, header recognised in HUNT
- err_cnt  out  ERR_W  count of failed frames, saturating at all-ones

Behaviour:
- Reset (rst=1 at an edge): state HUNT, header shift register, bit counter, accumulator, all outputs = 0. Reset mid-frame aborts the frame; no strobe, err_cnt cleared.
- bit_en=0: no state, counter, shift or accumulator change; frame_valid and head still drop to 0 after their pulse cycle.
- HUNT: on each accepted bit, header shreg <= {shreg[HEAD_W-2:0], data_in}. When the shifted value equals HEAD_PAT, head=1 next cycle, state -> PAYLOAD, bit counter = 0, accumulator = 0 (mode identity: 0 for both modes).
- Header bits are not part of the frame; the next accepted bit is payload word 0 MSB.
- PAYLOAD: accepted bits shift into the frame register; counter increments. On the bit completing each payload word, accumulator <= acc + word (mod 2^DATA_W) or acc ^ word per CHK_MODE, using the completed word including the current data_in bit.
- After NUM_BYTES*DATA_W bits -> state CHECK.
- CHECK: collects DATA_W checksum bits. On the edge accepting the last one:
  - out_data/out_chk load the frame;
  - check_ok <= (chk == acc);
  - frame_valid = 1 for the following cycle;
  - err_cnt increments on mismatch, unless all-ones;
  - state -> HUNT and the header shreg clears to 0, so a full fresh header is required. Header patterns inside payload/checksum are ignored, and head does not pulse there.
- Latency: frame_valid rises in the cycle after the edge that sampled the final checksum bit.
- out_data, out_chk and check_ok change only at a frame completion (or reset); they hold between frames.
- Counter width: $clog2((NUM_BYTES+1)*DATA_W+1); no wrap is possible within a frame.

Decomposition:
- Shared package seq_rx_pkg:
  - state encoding localparams (ST_HUNT, ST_PAYLOAD, ST_CHECK);
  - CHK_SUM/CHK_XOR constants;
  - a checksum-step function (acc, word, mode) reused by the transmitter model.
- One sub-module: seq_head_detect (HEAD_W/HEAD_PAT parametrised shift-compare, with enable and clear inputs, single-cycle hit output). Replaces the fixed-pattern detector.

Test Plan:
- Defaults, header A5 then words 12 34 56 78, chk 14 -> frame_valid one cycle, out_data=32'h12345678, out_chk=8'h14, check_ok=1, err_cnt=0.
- Same frame with chk 15 -> check_ok=0, err_cnt=1. Then a good frame -> check_ok=1, err_cnt stays 1.
- CHK_MODE=1, words 12 34 56 78, chk 08 -> check_ok=1; chk 14 -> check_ok=0.
- Payload word A5 embedded (A5 A5 00 00 4A) -> one frame only, head pulses once, check_ok=1. A header straddling the frame end is not detected until 8 new bits.
- bit_en toggled 1-0-1 per cycle during a good frame -> identical outputs, frame_valid only after the 48th accepted bit.
- rst=1 asserted after 20 payload bits, then a full good frame -> no strobe from the aborted frame, outputs 0 until the good frame, err_cnt=0.
- ERR_W=2, four bad frames -> err_cnt 1,2,3,3 (saturates).

Source files
------------

// File: rtl/seq_rx_pkg.sv
// Shared definitions for the serial frame receiver and its transmitter model:
// state encoding, checksum mode constants and the checksum accumulation step.
package seq_rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    localparam int CHK_SUM   = 0;
    localparam int CHK_XOR   = 1;
    localparam int CHK_MAX_W = 16;

    // Operates at the widest supported word; callers truncate to DATA_W,
    // which keeps the sum correct modulo 2^DATA_W.
    function automatic logic [CHK_MAX_W-1:0] chk_step(
        input logic [CHK_MAX_W-1:0] acc,
        input logic [CHK_MAX_W-1:0] word,
        input logic                 xor_mode
    );
        return xor_mode ? (acc ^ word) : (acc + word);
    endfunction

endpackage

// File: rtl/seq_head_detect.sv
// Parametrised header detector: shifts qualified bits MSB-first and flags a
// match against HEAD_PAT, both combinationally and as a registered pulse.
module seq_head_detect #(
    parameter int                 HEAD_W   = 8,
    parameter logic [HEAD_W-1:0]  HEAD_PAT = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic din,
    output logic match,
    output logic hit
);

    logic [HEAD_W-1:0] shreg;
    logic [HEAD_W-1:0] shifted;

    assign shifted = {shreg[HEAD_W-2:0], din};
    assign match   = en && (shifted == HEAD_PAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            hit   <= 1'b0;
        end else begin
            hit <= match;
            if (clr)
                shreg <= '0;
            else if (en)
                shreg <= shifted;
        end
    end

endmodule

// File: rtl/seq_frame_rx.sv
// Serial frame receiver: hunts a header, deserialises NUM_BYTES words plus a
// checksum word MSB first, verifies the checksum and counts failed frames.
module seq_frame_rx
    import seq_rx_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                NUM_BYTES = 4,
    parameter int                HEAD_W    = 8,
    parameter logic [HEAD_W-1:0] HEAD_PAT  = 8'hA5,
    parameter int                CHK_MODE  = CHK_SUM,
    parameter int                ERR_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_en,
    input  logic                          data_in,
    output logic [NUM_BYTES*DATA_W-1:0]   out_data,
    output logic [DATA_W-1:0]             out_chk,
    output logic                          frame_valid,
    output logic                          check_ok,
    output logic                          busy,
    output logic                          head,
    output logic [ERR_W-1:0]              err_cnt
);

    localparam int PAY_BITS = NUM_BYTES * DATA_W;
    localparam int FRM_BITS = PAY_BITS + DATA_W;
    localparam int CNT_W    = $clog2(FRM_BITS + 1);
    localparam int BPOS_W   = $clog2(DATA_W);

    localparam logic [CNT_W-1:0]  LAST_PAY = CNT_W'(PAY_BITS - 1);
    localparam logic [CNT_W-1:0]  LAST_CHK = CNT_W'(FRM_BITS - 1);
    localparam logic [BPOS_W-1:0] LAST_BIT = BPOS_W'(DATA_W - 1);
    localparam logic              XOR_MODE = (CHK_MODE == CHK_XOR);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [BPOS_W-1:0]     bpos;
    logic [PAY_BITS-1:0]   frame_sr;
    logic [DATA_W-1:0]     chk_sr;
    logic [DATA_W-1:0]     acc;
    logic [DATA_W-1:0]     word_now;
    logic [DATA_W-1:0]     chk_now;
    logic                  det_match;
    logic                  pay_bit;
    logic                  chk_bit;
    logic                  frame_done;

    assign pay_bit    = bit_en && (state == ST_PAYLOAD);
    assign chk_bit    = bit_en && (state == ST_CHECK);
    assign frame_done = chk_bit && (cnt == LAST_CHK);
    // Word completed by the current bit, including data_in itself.
    assign word_now   = {frame_sr[DATA_W-2:0], data_in};
    assign chk_now    = {chk_sr[DATA_W-2:0], data_in};
    assign busy       = (state != ST_HUNT);

    // Detector is cleared at frame end so a whole fresh header is required.
    seq_head_detect #(
        .HEAD_W   (HEAD_W),
        .HEAD_PAT (HEAD_PAT)
    ) u_head_detect (
        .clk   (clk),
        .rst   (rst),
        .en    (bit_en && (state == ST_HUNT)),
        .clr   (frame_done),
        .din   (data_in),
        .match (det_match),
        .hit   (head)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_HUNT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HUNT:    if (det_match) state_nxt = ST_PAYLOAD;
            ST_PAYLOAD: if (pay_bit && (cnt == LAST_PAY)) state_nxt = ST_CHECK;
            ST_CHECK:   if (frame_done) state_nxt = ST_HUNT;
            default:    state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            bpos        <= '0;
            acc         <= '0;
            frame_sr    <= '0;
            chk_sr      <= '0;
            out_data    <= '0;
            out_chk     <= '0;
            check_ok    <= 1'b0;
            frame_valid <= 1'b0;
            err_cnt     <= '0;
        end else begin
            frame_valid <= frame_done;
            if (det_match) begin
                cnt  <= '0;
                bpos <= '0;
                acc  <= '0;
            end
            if (pay_bit) begin
                frame_sr <= {frame_sr[PAY_BITS-2:0], data_in};
                cnt      <= cnt + CNT_W'(1);
                if (bpos == LAST_BIT) begin
                    bpos <= '0;
                    acc  <= DATA_W'(chk_step(CHK_MAX_W'(acc), CHK_MAX_W'(word_now), XOR_MODE));
                end else begin
                    bpos <= bpos + BPOS_W'(1);
                end
            end
            if (chk_bit) begin
                chk_sr <= chk_now;
                cnt    <= cnt + CNT_W'(1);
            end
            if (frame_done) begin
                out_data <= frame_sr;
                out_chk  <= chk_now;
                check_ok <= (chk_now == acc);
                if (chk_now != acc)
                    err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule
